// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the mult_sched multiplier scheduler.
// Optional feature macro: MULT_SCHED_SIGNED_EN (two's-complement operands).
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MUL_ITER      = 19;
  localparam int DEFAULT_OPW   = 18;
  localparam int DEFAULT_N_REQ = 3;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward,
// pointer moves past the granted requester when advance_i is strobed.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] grant_o
);

  localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTRW-1:0] ptr_q, ptr_d, gidx;
  logic            found;

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    grant_o = '0;
    gidx    = ptr_q;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % N_REQ]) begin
        grant_o[(int'(ptr_q) + k) % N_REQ] = 1'b1;
        gidx  = PTRW'((int'(ptr_q) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (gidx == PTRW'(N_REQ - 1)) ? '0 : gidx + PTRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Schedules N_REQ requesters onto one external shift-add multiplier with fixed
// 21-cycle latency. Define MULT_SCHED_SIGNED_EN for two's-complement operands.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*OPW-1:0] req_a,
  input  logic [N_REQ*OPW-1:0] req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [2*OPW-1:0]     rsp_p,
  output logic [OPW-1:0]       mul_a,
  output logic [OPW-1:0]       mul_b,
  input  logic [2*OPW-1:0]     mul_p,
  output logic                 busy
);

  localparam int CNTW = $clog2(MUL_ITER);

  state_e             state_q;
  logic [N_REQ-1:0]   grant, owner_q, req_ready_q, rsp_valid_q;
  logic [OPW-1:0]     sel_a, sel_b, lat_a, lat_b, opa_q, mul_a_q, mul_b_q;
  logic [2*OPW-1:0]   rsp_p_q;
  logic [CNTW-1:0]    cnt_q;
  logic               advance;

  assign advance = (state_q == IDLE) && (|req_valid);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_valid),
    .advance_i (advance),
    .grant_o   (grant)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[i*OPW +: OPW];
        sel_b = sel_b | req_b[i*OPW +: OPW];
      end
    end
  end

`ifdef MULT_SCHED_SIGNED_EN
  // Magnitudes feed the unsigned multiplier; the minimum value maps to 2^(OPW-1).
  logic sel_neg, neg_q;
  assign lat_a   = sel_a[OPW-1] ? -sel_a : sel_a;
  assign lat_b   = sel_b[OPW-1] ? -sel_b : sel_b;
  assign sel_neg = sel_a[OPW-1] ^ sel_b[OPW-1];
`else
  assign lat_a = sel_a;
  assign lat_b = sel_b;
`endif

  // FLUSH inverts mul_a for one cycle so the multiplier always sees a change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      opa_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      cnt_q       <= '0;
`ifdef MULT_SCHED_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (advance) begin
            req_ready_q <= grant;
            owner_q     <= grant;
            opa_q       <= lat_a;
            mul_a_q     <= ~lat_a;
            mul_b_q     <= lat_b;
`ifdef MULT_SCHED_SIGNED_EN
            neg_q       <= sel_neg;
`endif
            state_q     <= FLUSH;
          end
        end
        FLUSH: begin
          mul_a_q <= opa_q;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNTW'(MUL_ITER - 1)) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        DONE: begin
`ifdef MULT_SCHED_SIGNED_EN
          rsp_p_q <= neg_q ? -mul_p : mul_p;
`else
          rsp_p_q <= mul_p;
`endif
          rsp_valid_q <= owner_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched with a behavioural shift-add multiplier.
// Honours MULT_SCHED_SIGNED_EN when computing expected products.
module tb_mult_sched;

  localparam int N  = 3;
  localparam int W  = 18;
  localparam int PW = 2 * W;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a, req_b;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [PW-1:0]   rsp_p, mul_p;
  logic [W-1:0]    mul_a, mul_b;
  logic            busy;

  logic [W-1:0]    opA [N];
  logic [W-1:0]    opB [N];

  typedef struct {
    int            owner;
    logic [PW-1:0] prod;
    int            cyc;
  } exp_t;

  exp_t sbQ[$];

  int checks = 0, failures = 0, cycle = 0;
  int rrPtr = 0, lastAccept = -1, grantCount = 0;
  bit gapCheck = 0, holdValid = 0;

  mult_sched #(.N_REQ(N), .OPW(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opA[i];
      req_b[i*W +: W] = opB[i];
    end
  end

  // Shift-add multiplier: reloads whenever its operands change, then adds one bit per cycle.
  logic [W-1:0]  mLa = '0, mLb = '0;
  logic [PW-1:0] mAcc = '0;
  int            mStep = 0;

  always @(posedge clk) begin
    if (mul_a != mLa || mul_b != mLb) begin
      mLa   <= mul_a;
      mLb   <= mul_b;
      mAcc  <= '0;
      mStep <= 0;
    end else if (mStep < W) begin
      if (mLb[mStep]) mAcc <= mAcc + ({{W{1'b0}}, mLa} << mStep);
      mStep <= mStep + 1;
    end
  end

  assign mul_p = mAcc;

  function automatic logic [PW-1:0] expProd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] ea, eb;
`ifdef MULT_SCHED_SIGNED_EN
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
`else
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
`endif
    return ea * eb;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    opA[idx]       = a;
    opB[idx]       = b;
    req_valid[idx] = 1'b1;
  endtask

  // One cycle: sample at the falling edge, score accepts and responses.
  task automatic stepCycle();
    exp_t e;
    int   g;
    @(negedge clk);
    if (reset_n) begin
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(rrPtr + k) % N]) g = (rrPtr + k) % N;
        end
        checkOutput("grant", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        if (g >= 0) begin
          e.owner = g;
          e.prod  = expProd(opA[g], opB[g]);
          e.cyc   = cycle;
          sbQ.push_back(e);
          rrPtr = (g + 1) % N;
          grantCount++;
        end
        if (gapCheck && lastAccept >= 0) checkOutput("accept_gap", 64'(cycle - lastAccept), 64'd22);
        lastAccept = cycle;
        if (!holdValid) req_valid = req_valid & ~req_ready;
      end
      if (rsp_valid != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("rsp_owner", 64'(rsp_valid), 64'd1 << e.owner);
          checkOutput("rsp_p", 64'(rsp_p), 64'(e.prod));
          checkOutput("rsp_latency", 64'(cycle - e.cyc), 64'd21);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_valid != '0 || sbQ.size() != 0 || busy) && n < budget) begin
      stepCycle();
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", {61'd0, busy, sbQ.size() != 0, req_valid != '0}, 64'd0);
  endtask

  task automatic doReset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) stepCycle();
    sbQ.delete();
    rrPtr      = 0;
    lastAccept = -1;
    reset_n    = 1'b1;
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end

    doReset(3);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_p", 64'(rsp_p), 64'd0);
    checkOutput("reset_mul_a", 64'(mul_a), 64'd0);
    checkOutput("reset_mul_b", 64'(mul_b), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);

    // Single request
    applyStimulus(0, 18'd3, 18'd5);
    drain(100);

    // Identical operands back to back still restart the multiplier
    applyStimulus(0, 18'h3FFFF, 18'h3FFFF);
    drain(100);
    applyStimulus(0, 18'h3FFFF, 18'h3FFFF);
    drain(100);

    // All requesters held valid: round-robin from a fresh pointer
    doReset(2);
    gapCheck  = 1;
    holdValid = 1;
    grantCount = 0;
    opA[0] = 18'd11;     opB[0] = 18'd13;
    opA[1] = 18'd0;      opB[1] = 18'h01234;
    opA[2] = 18'h3FFFF;  opB[2] = 18'd2;
    req_valid = '1;
    n = 0;
    while (grantCount < 4 && n < 200) begin
      stepCycle();
      n++;
    end
    if (grantCount < 4) checkOutput("rr_timeout", 64'(grantCount), 64'd4);
    req_valid = '0;
    holdValid = 0;
    gapCheck  = 0;
    drain(100);

    // Reset in the middle of an operation discards it
    applyStimulus(0, 18'd7, 18'd9);
    n = 0;
    while (sbQ.size() == 0 && n < 20) begin
      stepCycle();
      n++;
    end
    if (sbQ.size() == 0) checkOutput("accept_timeout", 64'(sbQ.size()), 64'd1);
    repeat (9) stepCycle();
    reset_n = 1'b0;
    stepCycle();
    checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    doReset(1);
    repeat (25) stepCycle();
    applyStimulus(0, 18'd7, 18'd9);
    drain(100);

    // Sign-boundary operands
    applyStimulus(0, 18'h3FFFE, 18'd3);
    drain(100);
    applyStimulus(1, 18'h20000, 18'h20000);
    drain(100);

    checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters sharing the multiplier (1..8).
REQ-002 Parameter OPW, default 18, operand width; the product width is 2*OPW.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  N_REQ  per-requester request; the requester holds it and its operands stable until its req_ready bit pulses.
REQ-006 req_a  in  N_REQ*OPW  packed multiplicands; requester i uses slice i.
REQ-007 req_b  in  N_REQ*OPW  packed multipliers; requester i uses slice i.
REQ-008 req_ready  out  N_REQ  one-cycle accept pulse, one-hot.
REQ-009 rsp_valid  out  N_REQ  one-cycle result strobe, one-hot, to the owner of the operation.
REQ-010 rsp_p  out  2*OPW  result; valid only while any rsp_valid bit is high.
REQ-011 mul_a, mul_b  out  OPW each  registered operands to the shared shift-add multiplier.
REQ-012 mul_p  in  2*OPW  product returned by the shared multiplier.
REQ-013 busy  out  1  high in every state other than IDLE.

Function
REQ-014 States: IDLE, FLUSH, WAIT, DONE.
REQ-015 IDLE: if any req_valid bit is set, grant round-robin starting at the requester after the last granted one, pulse req_ready[g], latch the operands and owner, and go to FLUSH. Call this edge E0.
REQ-016 FLUSH: mul_a = ~latched_a and mul_b = latched_b for exactly one cycle, forcing the multiplier to restart even when the operands equal the previous pair; then go to WAIT with mul_a = latched_a.
REQ-017 WAIT: count 19 cycles with mul_a/mul_b held stable, then go to DONE. The multiplier loads at E2 and accumulates at E3..E20.
REQ-018 DONE: at E21, register rsp_p from mul_p (post-processed per REQ-026) and pulse rsp_valid[owner]; return to IDLE in the same edge.
REQ-019 Total latency is fixed: req_ready edge E0 to rsp_valid edge E21, independent of operand values.
REQ-020 A new grant is possible only in IDLE. The earliest re-grant edge is E22, so there is no overlap.
REQ-021 Round-robin pointer resets to requester 0; after each grant it points at g+1, wrapping from N_REQ-1 to 0.
REQ-022 req_valid deasserting outside IDLE has no effect. The latched operation completes.
REQ-023 Operands 0 or all-ones are legal and need no special case.

Reset
REQ-024 While reset_n is low at a clock edge: state goes to IDLE; req_ready, rsp_valid, rsp_p, mul_a and mul_b go to 0; busy goes to 0; the pointer goes to 0.
REQ-025 Reset mid-operation discards the operation with no rsp_valid. The next operation is correct because FLUSH always forces a multiplier restart.

Configuration
REQ-026 With macro MULT_SCHED_SIGNED_EN defined:
- Operands are OPW-bit two's complement.
- FLUSH/WAIT drive the magnitudes; magnitude of the minimum value is 2^(OPW-1) unsigned.
- rsp_p is negated (36-bit two's complement) when the operand signs differ.
- Latency is unchanged.
Without the macro, operands and result are unsigned and passed through unchanged.

Structure
REQ-027 Shared package holds the state enum, MUL_ITER = 19 (WAIT length) and default OPW/N_REQ constants.
REQ-028 One sub-module, rr_arbiter (N_REQ requests, advance strobe, one-hot grant, pointer register), is instantiated once. The multiplier sits outside this block.

Verification
REQ-029 Single request, req0 a=3, b=5 -> req_ready[0] at E0, rsp_valid[0] at E21, rsp_p=15.
REQ-030 Same operands twice, a=0x3FFFF, b=0x3FFFF -> both responses 0xFFFF80001, each 21 cycles after its own accept.
REQ-031 req0, req1, req2 all held valid -> grants 0, 1, 2, 0 in order, each accept 22 cycles apart.
REQ-032 Reset asserted at E10 of a=7, b=9, then re-request a=7, b=9 -> no rsp during reset; second rsp_p=63 at its E21.
REQ-033 MULT_SCHED_SIGNED_EN, a=-2 (0x3FFFE), b=3 -> rsp_p=0xFFFFFFFFA. Also a=0x20000, b=0x20000 -> rsp_p=0x400000000.
